prewish_blinky_multi: RTL
=========================

# prewish_blinky_multi

Multi-channel, parametrised successor of the single-LED blink-pattern peripheral. Each of NUM_CH channels replays a MASK_W-bit on/off pattern, one bit per divided-clock slot, either forever or for a programmed number of passes. Exposes a Wishbone-subset student port for per-channel mask/control writes and status readback, and sits between the bus master and the board LEDs.

## Interface

- NUM_CH, 4: number of LED channels (1..16).
- MASK_W, 16: pattern length in bits; also the data bus width. Must be ≥ CNT_W+2.
- CNT_W, 8: width of the pass-count field.
- DIV_BITS, 22: width of the shared free-running slot divider.
- ADR_W, derived $clog2(NUM_CH)+1: address width.

- CLK_I  in  1  system clock; the only clock.
- RST_I  in  1  reset, asynchronous, active-high.
- STB_I  in  1  student select strobe.
- WE_I  in  1  1 = write, 0 = read.
- ADR_I  in  ADR_W  {channel, reg}; reg 0 = MASK, reg 1 = CTRL/STATUS.
- DAT_I  in  MASK_W  write data.
- DAT_O  out  MASK_W  read data, registered.
- ACK_O  out  1  access acknowledge, registered.
- o_led  out  NUM_CH  LED drive, active-high, registered.
- o_alive  out  1  heartbeat = ckdiv[DIV_BITS-1].

## Operation

- Shared divider ckdiv free-runs; tick = (ckdiv == all ones). Bus writes never reset the divider.
- Per-channel registers: mask[MASK_W], en, counted, count[CNT_W], rem[CNT_W], idx[$clog2(MASK_W)], state ∈ {IDLE, RUN, DONE}, led.
- CTRL write: DAT_I[0] = EN, DAT_I[1] = COUNTED, DAT_I[CNT_W+1:2] = COUNT.
  - EN=0 → IDLE; led 0.
  - EN=1 → RUN; idx 0; rem ← COUNT; led 0 until next tick.
- MASK write: mask ← DAT_I. If RUN or DONE with en=1 → RUN, idx 0, rem ← count, led 0.
- Tick in RUN:
  - If counted and rem == 0 → DONE, led 0.
  - Otherwise led ← mask[MASK_W-1-idx] (MSB first); idx++.
  - At idx == MASK_W-1: idx wraps to 0; if counted, rem decrements.
- Tick in IDLE/DONE: no change; led stays 0.
- COUNTED with COUNT = N gives N×MASK_W visible slots; DONE on tick N×MASK_W+1. N = 0 → DONE on first tick.
- Reads:
  - MASK: DAT_O = mask.
  - STATUS: DAT_O = {zero-pad, rem, done, run} (bit0 run, bit1 done, bits CNT_W+1:2 rem).
- Out-of-range channel address: writes ignored, reads return 0, ACK still given.

## Timing

- Access accepted when STB_I=1 and ACK_O=0 at a rising edge. ACK_O ← STB_I & ~ACK_O, so every accepted access gets exactly one ACK cycle, one clock later. Master drops STB_I after ACK_O.
- Write takes effect at the accepting edge. DAT_O is valid in the ACK_O cycle and holds until the next read.
- Write and tick on the same edge for the same channel: the write wins, the tick is ignored for that channel, and the new pattern starts at the following tick.
- o_led updates on tick edges or write edges only; no combinational path from bus to LEDs.
- Reset (asynchronous, any time, including mid-pattern or mid-access) sets:
  - ckdiv, mask, count, rem, idx to 0; en, counted to 0; state IDLE.
  - o_led, ACK_O, DAT_O to 0; o_alive 0.
- First edge after reset release behaves as normal.

## Structure

- Package prewish_blinky_pkg holds:
  - channel state enum (IDLE/RUN/DONE);
  - register offsets REG_MASK=0, REG_CTRL=1;
  - CTRL/STATUS bit positions (EN, COUNTED, RUN, DONE, COUNT/REM LSB).
- Sub-module blinky_channel: one instance per channel via generate. Takes tick, write strobes and data; returns led, status.
- Top contains the divider, bus decode, ACK/DAT_O registers.

## Test plan

Bench settings: DIV_BITS=2 (tick every 4 cycles), NUM_CH=4, MASK_W=16, CNT_W=8.

- Async reset: assert RST_I between edges mid-pattern → o_led=0, ACK_O=0, DAT_O=0 immediately; after release, STATUS reads of all channels return 0.
- Continuous mode: ch0 MASK=0xA000, CTRL=0x0001 → o_led[0] per tick 1,0,1,0 then twelve 0s, repeating every 16 ticks; o_led[3:1] stay 0.
- Counted mode: ch1 MASK=0xFFFF, CTRL=0x000B (EN, COUNTED, COUNT=2) → o_led[1] high for 32 ticks then 0; STATUS reads 0x0002 (done=1, rem=0).
- Zero count: ch2 CTRL=0x0003 (COUNT=0) → DONE at first tick, o_led[2] never high.
- Write/tick collision: ch0 MASK=0x8000 written on a tick edge → o_led[0]=0 that slot; 1 on the next tick; 0 for the following 15.
- Bus: single-cycle STB_I read of ch0 MASK → ACK_O high exactly one cycle later, DAT_O=0xA000. Read of address 7 with NUM_CH=3 → ACK_O, DAT_O=0.

Source files
------------

// File: rtl/prewish_blinky_pkg.sv
// Shared types and register map for the multi-channel blink-pattern peripheral.
package prewish_blinky_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ch_state_e;

   localparam logic REG_MASK = 1'b0;
   localparam logic REG_CTRL = 1'b1;

   localparam int unsigned CTRL_EN        = 0;
   localparam int unsigned CTRL_COUNTED   = 1;
   localparam int unsigned CTRL_COUNT_LSB = 2;

   localparam int unsigned STAT_RUN     = 0;
   localparam int unsigned STAT_DONE    = 1;
   localparam int unsigned STAT_REM_LSB = 2;

endpackage

// File: rtl/blinky_channel.sv
// One LED channel: replays its mask MSB first, one bit per tick, forever or for a set number of passes.
module blinky_channel
   import prewish_blinky_pkg::*;
#(
   parameter int unsigned MASK_W = 16,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              wr_mask,
   input  logic              wr_ctrl,
   input  logic [MASK_W-1:0] wdata,
   output logic              led,
   output logic [MASK_W-1:0] mask,
   output logic [MASK_W-1:0] status_c
);

   localparam int unsigned IDX_W = (MASK_W > 1) ? $clog2(MASK_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MASK_W - 1);

   ch_state_e         state_q, state_d;
   logic              en_q, en_d;
   logic              counted_q, counted_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [MASK_W-1:0] mask_q, mask_d;
   logic              led_d;
   logic [IDX_W-1:0]  bit_sel_c;

   assign bit_sel_c = IDX_LAST - idx_q;
   assign mask      = mask_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         en_q      <= 1'b0;
         counted_q <= 1'b0;
         count_q   <= '0;
         rem_q     <= '0;
         idx_q     <= '0;
         mask_q    <= '0;
         led       <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         counted_q <= counted_d;
         count_q   <= count_d;
         rem_q     <= rem_d;
         idx_q     <= idx_d;
         mask_q    <= mask_d;
         led       <= led_d;
      end
   end

   // Bus writes take priority over a coincident tick; the new pattern starts on the next tick.
   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      counted_d = counted_q;
      count_d   = count_q;
      rem_d     = rem_q;
      idx_d     = idx_q;
      mask_d    = mask_q;
      led_d     = led;
      if (wr_ctrl) begin
         en_d      = wdata[CTRL_EN];
         counted_d = wdata[CTRL_COUNTED];
         count_d   = wdata[CTRL_COUNT_LSB +: CNT_W];
         rem_d     = wdata[CTRL_COUNT_LSB +: CNT_W];
         idx_d     = '0;
         led_d     = 1'b0;
         state_d   = wdata[CTRL_EN] ? ST_RUN : ST_IDLE;
      end else if (wr_mask) begin
         mask_d = wdata;
         if (state_q != ST_IDLE && en_q) begin
            state_d = ST_RUN;
            idx_d   = '0;
            rem_d   = count_q;
            led_d   = 1'b0;
         end
      end else if (tick && state_q == ST_RUN) begin
         if (counted_q && rem_q == '0) begin
            state_d = ST_DONE;
            led_d   = 1'b0;
         end else begin
            led_d = mask_q[bit_sel_c];
            if (idx_q == IDX_LAST) begin
               idx_d = '0;
               if (counted_q) begin
                  rem_d = rem_q - CNT_W'(1);
               end
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
      end
   end

   always_comb begin
      status_c                           = '0;
      status_c[STAT_RUN]                 = (state_q == ST_RUN);
      status_c[STAT_DONE]                = (state_q == ST_DONE);
      status_c[STAT_REM_LSB +: CNT_W]    = rem_q;
   end

endmodule

// File: rtl/prewish_blinky_multi.sv
// Multi-channel blink-pattern peripheral: shared slot divider, bus decode and registered bus responses.
module prewish_blinky_multi
   import prewish_blinky_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned MASK_W   = 16,
   parameter int unsigned CNT_W    = 8,
   parameter int unsigned DIV_BITS = 22,
   parameter int unsigned ADR_W    = $clog2(NUM_CH) + 1
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   input  logic              STB_I,
   input  logic              WE_I,
   input  logic [ADR_W-1:0]  ADR_I,
   input  logic [MASK_W-1:0] DAT_I,
   output logic [MASK_W-1:0] DAT_O,
   output logic              ACK_O,
   output logic [NUM_CH-1:0] o_led,
   output logic              o_alive
);

   logic [DIV_BITS-1:0] ckdiv;
   logic                tick_c;
   logic                acc_c;
   logic [ADR_W-1:0]    ch_sel_c;
   logic                reg_sel_c;
   logic                ch_ok_c;
   logic [NUM_CH-1:0]   wr_mask_c;
   logic [NUM_CH-1:0]   wr_ctrl_c;
   logic [MASK_W-1:0]   rd_data_c;
   logic [MASK_W-1:0]   ch_mask   [NUM_CH];
   logic [MASK_W-1:0]   ch_status [NUM_CH];

   assign tick_c    = &ckdiv;
   assign o_alive   = ckdiv[DIV_BITS-1];
   assign acc_c     = STB_I & ~ACK_O;
   assign ch_sel_c  = ADR_I >> 1;
   assign reg_sel_c = ADR_I[0];
   assign ch_ok_c   = (ch_sel_c < ADR_W'(NUM_CH));

   // Per-channel write strobes; out-of-range channels decode to nothing.
   always_comb begin
      wr_mask_c = '0;
      wr_ctrl_c = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (acc_c && WE_I && ch_ok_c && ch_sel_c == ADR_W'(i)) begin
            wr_mask_c[i] = (reg_sel_c == REG_MASK);
            wr_ctrl_c[i] = (reg_sel_c == REG_CTRL);
         end
      end
   end

   always_comb begin
      rd_data_c = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ch_sel_c == ADR_W'(i)) begin
            rd_data_c = (reg_sel_c == REG_CTRL) ? ch_status[i] : ch_mask[i];
         end
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         ckdiv <= '0;
         ACK_O <= 1'b0;
         DAT_O <= '0;
      end else begin
         ckdiv <= ckdiv + DIV_BITS'(1);
         ACK_O <= acc_c;
         if (acc_c && !WE_I) begin
            DAT_O <= rd_data_c;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      blinky_channel #(
         .MASK_W (MASK_W),
         .CNT_W  (CNT_W)
      ) u_ch (
         .clk      (CLK_I),
         .rst      (RST_I),
         .tick     (tick_c),
         .wr_mask  (wr_mask_c[g]),
         .wr_ctrl  (wr_ctrl_c[g]),
         .wdata    (DAT_I),
         .led      (o_led[g]),
         .mask     (ch_mask[g]),
         .status_c (ch_status[g])
      );
   end

endmodule
